// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: captures operands, drives the external
// multiplier and divider cores, stalls the pipeline and issues a single HI/LO write.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  input  logic        stall_in,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_res,
  output logic        div_start,
  output logic        div_cancel,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        mdu_stall,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        div_start_q, div_start_d;
  logic        accept;

  assign accept = (state_q == IDLE) && startE && !flushE;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    div_start_d = 1'b0;
    if (flushE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (startE) begin
            op_d = opE;
            a_d  = srcaE;
            b_d  = srcbE;
            if (!opE[1]) begin
              state_d = MUL;
              cnt_d   = CNT_INIT;
            end else if (srcbE != '0) begin
              state_d     = DIV;
              div_start_d = 1'b1;
            end else begin
              // Divide by zero never reaches the core; result is fixed.
              state_d = DONE;
              hi_d    = srcaE;
              lo_d    = '1;
            end
          end
        end
        MUL: begin
          if (cnt_q == '0) begin
            hi_d    = mul_res[63:32];
            lo_d    = mul_res[31:0];
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DIV: begin
          if (div_done) begin
            hi_d    = div_r;
            lo_d    = div_q;
            state_d = DONE;
          end
        end
        DONE: begin
          if (!stall_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      div_start_q <= div_start_d;
    end
  end

  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign mul_signed = ~op_q[0];
  assign div_signed = ~op_q[0];
  assign div_start  = div_start_q;
  assign div_cancel = (state_q == DIV) && flushE;
  // Gated by resetn so a pending startE cannot raise a stall while in reset.
  assign mdu_stall  = resetn && (accept || (state_q == MUL) || (state_q == DIV));
  assign hilo_we    = (state_q == DONE) && !stall_in && !flushE;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: multiplier modelled combinationally, divider
// responses driven by hand with precomputed quotient/remainder.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE, srcbE;
  logic        flushE, stall_in;
  logic [31:0] mul_a, mul_b;
  logic        mul_signed;
  logic [63:0] mul_res;
  logic        div_start, div_cancel, div_signed;
  logic [31:0] div_a, div_b;
  logic        div_done;
  logic [31:0] div_q, div_r;
  logic        mdu_stall, hilo_we;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;
  int n;
  int starts;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_LAT(3)) dut (
    .clk(clk), .resetn(resetn), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .flushE(flushE), .stall_in(stall_in),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .mul_res(mul_res),
    .div_start(div_start), .div_cancel(div_cancel), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_q(div_q),
    .div_r(div_r), .mdu_stall(mdu_stall), .hilo_we(hilo_we),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  logic [63:0] ea, eb;
  always_comb begin
    ea      = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'h0, mul_a};
    eb      = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'h0, mul_b};
    mul_res = ea * eb;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    startE = 1'b1;
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    settle();
  endtask

  task automatic run_mul(output int cycles);
    cycles = 0;
    while (mdu_stall && cycles < 50) begin
      cycles++;
      cyc();
      startE = 1'b0;
      settle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; startE = 1'b1; opE = 2'b00; srcaE = 32'd5; srcbE = 32'd6;
    flushE = 1'b0; stall_in = 1'b0; div_done = 1'b0; div_q = '0; div_r = '0;
    #3;
    check("rst_stall", mdu_stall, 0);
    check("rst_hilo_we", hilo_we, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_div_b", div_b, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_cancel", div_cancel, 0);
    startE = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;

    // MULTU FFFFFFFF * 2, issued in the first cycle after reset release
    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    run_mul(n);
    check("multu_stall_cycles", n, 4);
    check("multu_signed", mul_signed, 0);
    check("multu_we", hilo_we, 1);
    check("multu_hi", hi_o, 32'h0000_0001);
    check("multu_lo", lo_o, 32'hFFFF_FFFE);
    cyc(); settle();
    check("multu_we_once", hilo_we, 0);

    // DIV -7 / 2, divider done in its 5th cycle
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    n = 0; starts = 0;
    while (mdu_stall && n < 50) begin
      if (div_start) starts++;
      n++;
      cyc();
      startE   = 1'b0;
      div_done = (n == 5);
      div_q    = 32'hFFFF_FFFD;
      div_r    = 32'hFFFF_FFFF;
      settle();
      if (n == 1) begin
        check("div_signed", div_signed, 1);
        check("div_a", div_a, 32'hFFFF_FFF9);
      end
    end
    check("div_stall_cycles", n, 6);
    check("div_start_pulses", starts, 1);
    check("div_we", hilo_we, 1);
    check("div_hi", hi_o, 32'hFFFF_FFFF);
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    cyc(); settle();
    check("div_we_once", hilo_we, 0);

    // DIVU 100 / 7 with div_done coincident with div_start
    issue(2'b11, 32'd100, 32'd7);
    n = 0;
    while (mdu_stall && n < 50) begin
      n++;
      cyc();
      startE   = 1'b0;
      div_done = (n == 1);
      div_q    = 32'd14;
      div_r    = 32'd2;
      settle();
      if (n == 1) check("divu_fast_start", div_start, 1);
    end
    check("divu_fast_cycles", n, 2);
    check("divu_fast_hi", hi_o, 32'd2);
    check("divu_fast_lo", lo_o, 32'd14);
    cyc(); settle();

    // DIVU by zero: no core start, DONE next cycle
    issue(2'b11, 32'h1234_5678, 32'd0);
    check("dz_stall", mdu_stall, 1);
    cyc(); startE = 1'b0; settle();
    check("dz_no_start", div_start, 0);
    check("dz_stall_done", mdu_stall, 0);
    check("dz_we", hilo_we, 1);
    check("dz_hi", hi_o, 32'h1234_5678);
    check("dz_lo", lo_o, 32'hFFFF_FFFF);
    cyc(); settle();

    // startE with flushE in IDLE is not captured
    flushE = 1'b1;
    issue(2'b00, 32'hAAAA_AAAA, 32'd3);
    check("flush_idle_stall", mdu_stall, 0);
    cyc(); startE = 1'b0; flushE = 1'b0; settle();
    check("flush_idle_nocap", mul_a, 32'h1234_5678);
    check("flush_idle_state", mdu_stall, 0);

    // DIV flushed in its 3rd cycle; late div_done ignored
    issue(2'b10, 32'd100, 32'd3);
    cyc(); startE = 1'b0; settle();
    check("fl_start_c1", div_start, 1);
    cyc(); settle();
    check("fl_start_c2", div_start, 0);
    cyc(); flushE = 1'b1; settle();
    check("fl_cancel", div_cancel, 1);
    check("fl_we", hilo_we, 0);
    cyc(); flushE = 1'b0; div_done = 1'b1; div_q = 32'd33; div_r = 32'd1; settle();
    check("fl_cancel_once", div_cancel, 0);
    check("fl_idle", mdu_stall, 0);
    cyc(); div_done = 1'b0; settle();
    check("fl_no_we", hilo_we, 0);
    check("fl_hi_kept", hi_o, 32'h1234_5678);
    check("fl_lo_kept", lo_o, 32'hFFFF_FFFF);

    // MULT -3 * 5 completing under stall_in for 3 cycles
    stall_in = 1'b1;
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    run_mul(n);
    check("mst_stall_cycles", n, 4);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("mst_we_%0d", d), hilo_we, (d == 3));
      check($sformatf("mst_hi_%0d", d), hi_o, 32'hFFFF_FFFF);
      check($sformatf("mst_lo_%0d", d), lo_o, 32'hFFFF_FFF1);
      cyc();
      startE = (d == 0);
      opE = 2'b01; srcaE = 32'd1; srcbE = 32'd1;
      stall_in = (d < 2);
      settle();
      if (d == 0) check("mst_done_ignore", mdu_stall, 0);
    end
    check("mst_we_end", hilo_we, 0);
    check("mst_no_capture", mul_a, 32'hFFFF_FFFD);

    // Reset mid-MUL, then a normal MULT 7 * -6
    issue(2'b01, 32'd7, 32'd6);
    cyc(); startE = 1'b0; cyc(); settle();
    check("rm_in_mul", mdu_stall, 1);
    resetn = 1'b0;
    #1;
    check("rm_stall", mdu_stall, 0);
    check("rm_mul_a", mul_a, 0);
    check("rm_mul_b", mul_b, 0);
    check("rm_hi", hi_o, 0);
    check("rm_lo", lo_o, 0);
    check("rm_we", hilo_we, 0);
    check("rm_cancel", div_cancel, 0);
    cyc(); cyc();
    resetn = 1'b1;
    issue(2'b00, 32'd7, 32'hFFFF_FFFA);
    run_mul(n);
    check("rm_mult_cycles", n, 4);
    check("rm_mult_we", hilo_we, 1);
    check("rm_mult_hi", hi_o, 32'hFFFF_FFFF);
    check("rm_mult_lo", lo_o, 32'hFFFF_FFD6);
    cyc(); settle();
    check("rm_mult_we_once", hilo_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
